// File: rtl/rgb_frame_sequencer.sv
// rgb_frame_sequencer: frames an unframed pixel stream into an AXI4-Stream
// video stream (tuser = start of frame, tlast = end of line).
// Optional feature macro: RGB_SEQ_FRAME_CNT_EN adds a 32-bit frame_count output.
//
// Handshakes: a beat moves when valid and ready are both high at a rising
// clock edge. A source holding valid may not drop it or change data until
// ready is seen; ready may be given or withdrawn freely.
module rgb_frame_sequencer #(
  parameter int C_rgb_m_axis_TDATA_WIDTH = 16,
  parameter int C_rgb_m_axis_START_COUNT = 32,
  parameter int conf_data_width          = 32,
  parameter int conf_addr_width          = 8,
  parameter int img_width                = 200,
  parameter int img_height               = 200,
  parameter int GAP_CYCLES               = 4
) (
  input  logic                                rgb_m_axis_aclk,
  input  logic                                rgb_m_axis_aresetn,
  input  logic                                cfg_wr_en,
  input  logic [conf_addr_width-1:0]          cfg_addr,
  input  logic [conf_data_width-1:0]          cfg_wdata,
  input  logic                                s_pix_valid,
  input  logic [C_rgb_m_axis_TDATA_WIDTH-1:0] s_pix_data,
  output logic                                s_pix_ready,
  output logic                                rgb_m_axis_tvalid,
  output logic [C_rgb_m_axis_TDATA_WIDTH-1:0] rgb_m_axis_tdata,
  output logic                                rgb_m_axis_tuser,
  output logic                                rgb_m_axis_tlast,
  input  logic                                rgb_m_axis_tready,
  output logic                                busy,
  output logic                                frame_done,
`ifdef RGB_SEQ_FRAME_CNT_EN
  output logic [31:0]                         frame_count,
`endif
  output logic [1:0]                          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_ACTIVE     = 2'd2,
    S_GAP        = 2'd3
  } state_t;

  localparam logic [31:0] START_LAST = 32'(C_rgb_m_axis_START_COUNT - 1);
  localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
  localparam logic [conf_addr_width-1:0] ADDR_CTRL   = conf_addr_width'(8'h00);
  localparam logic [conf_addr_width-1:0] ADDR_WIDTH  = conf_addr_width'(8'h04);
  localparam logic [conf_addr_width-1:0] ADDR_HEIGHT = conf_addr_width'(8'h08);

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [15:0] col_q, row_q;
  logic [15:0] w_sh_q, h_sh_q;
  logic        ctrl_en_q, ctrl_ss_q;
  logic [15:0] width_q, height_q;
  logic        tvalid_q, tuser_q, tlast_q, eof_q;
  logic [C_rgb_m_axis_TDATA_WIDTH-1:0] tdata_q;

  logic        pix_acc;
  logic        col_last, row_last, frame_last;
  logic [15:0] w_eff, h_eff;
  logic        unused_wdata;

  // Upper write-data bits only matter for the optional counter clear.
  assign unused_wdata = ^cfg_wdata[conf_data_width-1:16];

  // A zero-sized geometry register behaves as size 1.
  assign w_eff = (width_q  == 16'd0) ? 16'd1 : width_q;
  assign h_eff = (height_q == 16'd0) ? 16'd1 : height_q;

  assign col_last   = (col_q == w_sh_q - 16'd1);
  assign row_last   = (row_q == h_sh_q - 16'd1);
  assign frame_last = col_last & row_last;

  // Upstream is accepted only in ACTIVE and only when the slice can take a beat.
  assign s_pix_ready = (state_q == S_ACTIVE) & (~tvalid_q | rgb_m_axis_tready);
  assign pix_acc     = s_pix_ready & s_pix_valid;

  assign rgb_m_axis_tvalid = tvalid_q;
  assign rgb_m_axis_tdata  = tdata_q;
  assign rgb_m_axis_tuser  = tuser_q;
  assign rgb_m_axis_tlast  = tlast_q;
  assign frame_done        = tvalid_q & rgb_m_axis_tready & eof_q;
  assign busy              = (state_q != S_IDLE);
  assign dbg_state         = state_q;

  // Configuration registers; single-shot drops enable once its frame is fully taken in.
  always_ff @(posedge rgb_m_axis_aclk) begin
    if (!rgb_m_axis_aresetn) begin
      ctrl_en_q <= 1'b0;
      ctrl_ss_q <= 1'b0;
      width_q   <= 16'(img_width);
      height_q  <= 16'(img_height);
    end else begin
      if (pix_acc && frame_last && ctrl_ss_q) begin
        ctrl_en_q <= 1'b0;
      end
      if (cfg_wr_en) begin
        if (cfg_addr == ADDR_CTRL) begin
          ctrl_en_q <= cfg_wdata[0];
          ctrl_ss_q <= cfg_wdata[1];
        end else if (cfg_addr == ADDR_WIDTH) begin
          width_q <= cfg_wdata[15:0];
        end else if (cfg_addr == ADDR_HEIGHT) begin
          height_q <= cfg_wdata[15:0];
        end
      end
    end
  end

  // Frame sequencing FSM: start delay, pixel/line counting, inter-frame gap.
  always_ff @(posedge rgb_m_axis_aclk) begin
    if (!rgb_m_axis_aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      col_q   <= 16'd0;
      row_q   <= 16'd0;
      w_sh_q  <= 16'd1;
      h_sh_q  <= 16'd1;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= 32'd0;
          if (ctrl_en_q) state_q <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (!ctrl_en_q) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
          end else if (cnt_q == START_LAST) begin
            state_q <= S_ACTIVE;
            cnt_q   <= 32'd0;
            col_q   <= 16'd0;
            row_q   <= 16'd0;
            w_sh_q  <= w_eff;
            h_sh_q  <= h_eff;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        S_ACTIVE: begin
          if (pix_acc) begin
            if (col_last) begin
              col_q <= 16'd0;
              if (row_last) begin
                state_q <= S_GAP;
                cnt_q   <= 32'd0;
              end else begin
                row_q <= row_q + 16'd1;
              end
            end else begin
              col_q <= col_q + 16'd1;
            end
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q <= 32'd0;
            if (ctrl_en_q && !ctrl_ss_q) begin
              state_q <= S_ACTIVE;
              col_q   <= 16'd0;
              row_q   <= 16'd0;
              w_sh_q  <= w_eff;
              h_sh_q  <= h_eff;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Output register slice: load on upstream accept, hold while stalled, clear when drained.
  always_ff @(posedge rgb_m_axis_aclk) begin
    if (!rgb_m_axis_aresetn) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      eof_q    <= 1'b0;
    end else if (pix_acc) begin
      tvalid_q <= 1'b1;
      tdata_q  <= s_pix_data;
      tuser_q  <= (col_q == 16'd0) && (row_q == 16'd0);
      tlast_q  <= col_last;
      eof_q    <= frame_last;
    end else if (rgb_m_axis_tready) begin
      tvalid_q <= 1'b0;
    end
  end

`ifdef RGB_SEQ_FRAME_CNT_EN
  // Completed-frame counter; a CTRL write with bit 31 set clears it.
  always_ff @(posedge rgb_m_axis_aclk) begin
    if (!rgb_m_axis_aresetn) begin
      frame_count <= 32'd0;
    end else if (cfg_wr_en && (cfg_addr == ADDR_CTRL) && cfg_wdata[31]) begin
      frame_count <= 32'd0;
    end else if (frame_done) begin
      frame_count <= frame_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rgb_frame_sequencer.sv
// Self-checking bench for rgb_frame_sequencer: a frame-level model predicts
// every output beat from the configured geometry, plus directed scenarios.
module tb_rgb_frame_sequencer;

  localparam int DW       = 16;
  localparam int START_CN = 32;

  // ---------------- clock / reset ----------------
  logic clk;
  logic aresetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          cfg_wr_en;
  logic [7:0]    cfg_addr;
  logic [31:0]   cfg_wdata;
  logic          s_pix_valid;
  logic [DW-1:0] s_pix_data;
  logic          s_pix_ready;
  logic          tvalid, tuser, tlast, tready;
  logic [DW-1:0] tdata;
  logic          busy, frame_done;
  logic [1:0]    dbg_state;
`ifdef RGB_SEQ_FRAME_CNT_EN
  logic [31:0]   frame_count;
`endif

  rgb_frame_sequencer dut (
    .rgb_m_axis_aclk    (clk),
    .rgb_m_axis_aresetn (aresetn),
    .cfg_wr_en          (cfg_wr_en),
    .cfg_addr           (cfg_addr),
    .cfg_wdata          (cfg_wdata),
    .s_pix_valid        (s_pix_valid),
    .s_pix_data         (s_pix_data),
    .s_pix_ready        (s_pix_ready),
    .rgb_m_axis_tvalid  (tvalid),
    .rgb_m_axis_tdata   (tdata),
    .rgb_m_axis_tuser   (tuser),
    .rgb_m_axis_tlast   (tlast),
    .rgb_m_axis_tready  (tready),
    .busy               (busy),
    .frame_done         (frame_done),
`ifdef RGB_SEQ_FRAME_CNT_EN
    .frame_count        (frame_count),
`endif
    .dbg_state          (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Geometry the bench has written (model view of WIDTH/HEIGHT registers).
  int cfg_w = 200;
  int cfg_h = 200;
  logic toggle_mode = 1'b0;

  // Scoreboard: {eof, tuser, tlast, data}
  logic [DW+2:0] exp_q[$];
  int   m_idx = 0;
  int   m_w   = 1;
  int   m_h   = 1;
  int   beats = 0;
  int   fd_cnt = 0;
  logic tu_hist [0:4095];
  logic tl_hist [0:4095];
  logic prev_stall = 1'b0;
  logic [DW+1:0] prev_beat;

  // ---------------- drivers ----------------
  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  // Always-valid source; data advances after each accepted pixel.
  initial begin
    logic acc;
    s_pix_data = 16'h1000;
    forever begin
      @(negedge clk);
      acc = s_pix_valid & s_pix_ready & aresetn;
      @(posedge clk);
      #1;
      if (acc) s_pix_data = s_pix_data + 16'h0111;
    end
  end

  // Downstream ready: constant 1, or toggling every cycle.
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = toggle_mode ? ~tready : 1'b1;
    end
  end

  // ---------------- model + compare (every negedge) ----------------
  initial begin
    logic [DW+2:0] e;
    logic fd_exp;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        exp_q.delete();
        m_idx = 0;
        prev_stall = 1'b0;
      end else begin
        check("tvalid_vs_model", {31'd0, tvalid}, {31'd0, exp_q.size() != 0});
        if (prev_stall && tvalid)
          check("stall_hold", {14'd0, tuser, tlast, tdata}, {14'd0, prev_beat});
        fd_exp = 1'b0;
        if (tvalid && tready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("tdata", {16'd0, tdata}, {16'd0, e[DW-1:0]});
            check("tlast", {31'd0, tlast}, {31'd0, e[DW]});
            check("tuser", {31'd0, tuser}, {31'd0, e[DW+1]});
            fd_exp = e[DW+2];
            if (beats < 4096) begin
              tu_hist[beats] = tuser;
              tl_hist[beats] = tlast;
            end
            beats++;
          end
        end
        check("frame_done", {31'd0, frame_done}, {31'd0, fd_exp});
        if (frame_done) fd_cnt++;
        check("ready_while_stalled", {31'd0, s_pix_ready & tvalid & ~tready}, 32'd0);
        if (s_pix_valid && s_pix_ready) begin
          if (m_idx == 0) begin
            m_w = (cfg_w == 0) ? 1 : cfg_w;
            m_h = (cfg_h == 0) ? 1 : cfg_h;
          end
          exp_q.push_back({(m_idx == m_w * m_h - 1), (m_idx == 0),
                           ((m_idx % m_w) == m_w - 1), s_pix_data});
          m_idx++;
          if (m_idx == m_w * m_h) m_idx = 0;
        end
        prev_stall = tvalid & ~tready;
        prev_beat  = {tuser, tlast, tdata};
      end
    end
  end

  // ---------------- helpers for directed scenarios ----------------
  int base_beat = 0;
  int base_fd   = 0;

  task automatic mark();
    base_beat = beats;
    base_fd   = fd_cnt;
  endtask

  task automatic wait_beats(input int n);
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (beats - base_beat >= n) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("wait_beats_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy && !tvalid) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("wait_idle_timeout", ok, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mask_of(input logic is_last, input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < n && i < 32; i++)
      m[i] = is_last ? tl_hist[base_beat + i] : tu_hist[base_beat + i];
    return m;
  endfunction

  // Counts cycles where busy or s_pix_ready show up while the block should stay idle.
  task automatic expect_quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || s_pix_ready) bad++;
    end
    check(name, bad, 0);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    aresetn     = 1'b0;
    cfg_wr_en   = 1'b0;
    cfg_addr    = 8'h00;
    cfg_wdata   = 32'd0;
    s_pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata",  {16'd0, tdata}, 32'd0);
    check("rst_tuser",  {31'd0, tuser}, 32'd0);
    check("rst_tlast",  {31'd0, tlast}, 32'd0);
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_ready",  {31'd0, s_pix_ready}, 32'd0);
    check("rst_state",  {30'd0, dbg_state}, 32'd0);
    aresetn = 1'b1;

    // 1: 4x2 frame, full throughput, first-beat latency
    cfg_write(8'h04, 32'd4); cfg_w = 4;
    cfg_write(8'h08, 32'd2); cfg_h = 2;
    mark();
    cfg_write(8'h00, 32'd1);
    n = 0;
    while (!tvalid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_tvalid_latency", n, START_CN + 2);
    cfg_write(8'h00, 32'd0);
    wait_idle();
    check("t1_beats", beats - base_beat, 8);
    check("t1_frame_done", fd_cnt - base_fd, 1);
    check("t1_tuser_mask", mask_of(1'b0, 8), 32'h01);
    check("t1_tlast_mask", mask_of(1'b1, 8), 32'h88);

    // 2: same geometry, tready toggling
    toggle_mode = 1'b1;
    mark();
    cfg_write(8'h00, 32'd1);
    wait_beats(1);
    cfg_write(8'h00, 32'd0);
    wait_idle();
    toggle_mode = 1'b0;
    check("t2_beats", beats - base_beat, 8);
    check("t2_frame_done", fd_cnt - base_fd, 1);
    check("t2_tlast_mask", mask_of(1'b1, 8), 32'h88);

    // 3: single-shot 3x1 frame
    cfg_write(8'h04, 32'd3); cfg_w = 3;
    cfg_write(8'h08, 32'd1); cfg_h = 1;
    mark();
    cfg_write(8'h00, 32'd3);
    wait_beats(1);
    wait_idle();
    expect_quiet("t3_no_restart", 80);
    check("t3_beats", beats - base_beat, 3);
    check("t3_frame_done", fd_cnt - base_fd, 1);
    check("t3_tuser_mask", mask_of(1'b0, 3), 32'h1);
    check("t3_tlast_mask", mask_of(1'b1, 3), 32'h4);

    // 4: WIDTH rewritten mid-frame applies to the next frame only
    cfg_write(8'h04, 32'd4); cfg_w = 4;
    cfg_write(8'h08, 32'd2); cfg_h = 2;
    mark();
    cfg_write(8'h00, 32'd1);
    wait_beats(2);
    cfg_write(8'h04, 32'd6); cfg_w = 6;
    wait_beats(10);
    cfg_write(8'h00, 32'd0);
    wait_idle();
    check("t4_beats", beats - base_beat, 20);
    check("t4_frame_done", fd_cnt - base_fd, 2);
    check("t4_tlast_mask", mask_of(1'b1, 20), 32'h82088);
    check("t4_tuser_mask", mask_of(1'b0, 20), 32'h101);

    // 5: enable cleared at pixel 5 never truncates the frame
    cfg_write(8'h04, 32'd4); cfg_w = 4;
    mark();
    cfg_write(8'h00, 32'd1);
    wait_beats(5);
    cfg_write(8'h00, 32'd0);
    wait_idle();
    check("t5_beats", beats - base_beat, 8);
    check("t5_frame_done", fd_cnt - base_fd, 1);
    expect_quiet("t5_quiet_after", 50);

    // 6: reset at pixel 3, then a fresh frame
    mark();
    cfg_write(8'h00, 32'd1);
    wait_beats(3);
    aresetn = 1'b0;
    @(posedge clk);
    #1;
    check("t6_rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    aresetn = 1'b1;
    cfg_w = 200;
    cfg_h = 200;
    cfg_write(8'h04, 32'd4); cfg_w = 4;
    cfg_write(8'h08, 32'd2); cfg_h = 2;
    mark();
    cfg_write(8'h00, 32'd1);
    wait_beats(1);
    cfg_write(8'h00, 32'd0);
    wait_idle();
    check("t6_beats", beats - base_beat, 8);
    check("t6_tuser_mask", mask_of(1'b0, 8), 32'h01);
    check("t6_frame_done", fd_cnt - base_fd, 1);
`ifdef RGB_SEQ_FRAME_CNT_EN
    check("t6_frame_count", frame_count, 32'd1);
    cfg_write(8'h00, 32'h8000_0000);
    #1;
    check("t6_frame_count_clr", frame_count, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
